// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci LFSR with seed load, lock-up guard and period measurement
// Advances STEP single shifts per enabled cycle; wrap/period are measured against the last seed (anchor).
module lfsr_gen #(
   parameter int unsigned WIDTH = 16,
   parameter logic [31:0] TAPS  = 32'h0000_B400,
   parameter bit          XNOR  = 1'b1,
   parameter logic [31:0] INIT  = 32'h0000_0000,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] step_cnt,
   output logic             lock_err
);

   localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
   localparam logic [WIDTH-1:0] INIT_V   = INIT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] LOCKUP   = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] anchor_q, anchor_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
   logic             wrap_q, wrap_d;
   logic             lock_err_q, lock_err_d;
   logic [WIDTH-1:0] nxt;

   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
      logic fb;
      fb = (^(s & TAP_MASK)) ^ XNOR;
      return {s[WIDTH-2:0], fb};
   endfunction

   always_comb begin
      nxt = out_q;
      for (int unsigned i = 0; i < STEP; i++) begin
         nxt = shift1(nxt);
      end
   end

   always_comb begin
      out_d      = out_q;
      anchor_d   = anchor_q;
      period_d   = period_q;
      step_cnt_d = step_cnt_q;
      wrap_d     = 1'b0;
      lock_err_d = 1'b0;
      if (load) begin
         // A lock-up seed would freeze the generator, so fall back to INIT instead.
         step_cnt_d = '0;
         if (seed_in == LOCKUP) begin
            out_d      = INIT_V;
            anchor_d   = INIT_V;
            lock_err_d = 1'b1;
         end else begin
            out_d    = seed_in;
            anchor_d = seed_in;
         end
      end else if (enable) begin
         out_d = nxt;
         if (nxt == anchor_q) begin
            wrap_d     = 1'b1;
            period_d   = step_cnt_q + 1'b1;
            step_cnt_d = '0;
         end else if (step_cnt_q != CNT_MAX) begin
            step_cnt_d = step_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q      <= INIT_V;
         anchor_q   <= INIT_V;
         period_q   <= '0;
         step_cnt_q <= '0;
         wrap_q     <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         anchor_q   <= anchor_d;
         period_q   <= period_d;
         step_cnt_q <= step_cnt_d;
         wrap_q     <= wrap_d;
         lock_err_q <= lock_err_d;
      end
   end

   assign out      = out_q;
   assign wrap     = wrap_q;
   assign period   = period_q;
   assign step_cnt = step_cnt_q;
   assign lock_err = lock_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen
// Three configurations share one stimulus stream and are tracked by a behavioural reference model.
module tb_lfsr_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] seed16 = '0;

   logic [15:0] o0, p0, c0;
   logic        w0, l0;
   logic [15:0] o1, p1, c1;
   logic        w1, l1;
   logic [3:0]  o2, p2, c2;
   logic        w2, l2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lfsr_gen u_d0 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed16),
      .out(o0), .wrap(w0), .period(p0), .step_cnt(c0), .lock_err(l0)
   );

   lfsr_gen #(.STEP(4)) u_d1 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed16),
      .out(o1), .wrap(w1), .period(p1), .step_cnt(c1), .lock_err(l1)
   );

   lfsr_gen #(.WIDTH(4), .TAPS(32'hC), .XNOR(1'b0), .INIT(32'h1)) u_d2 (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed16[3:0]),
      .out(o2), .wrap(w2), .period(p2), .step_cnt(c2), .lock_err(l2)
   );

   int          p_w[3];
   logic [31:0] p_taps[3];
   int          p_xnor[3];
   logic [31:0] p_init[3];
   int          p_step[3];

   logic [31:0] m_out[3], m_anchor[3], m_period[3], m_cnt[3];
   logic [31:0] m_wrap[3], m_lock[3];

   function automatic logic [31:0] mask_of(input int k);
      return (32'h1 << p_w[k]) - 32'h1;
   endfunction

   function automatic logic [31:0] m_next(input int k, input logic [31:0] s);
      int fb;
      fb = ($countones(s & p_taps[k]) % 2) ^ p_xnor[k];
      return ((s << 1) | fb) & mask_of(k);
   endfunction

   task automatic model_clk(input bit rst, input bit en, input bit ld, input logic [31:0] sd);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] mask, s, lockv, nx;
         mask  = mask_of(k);
         s     = sd & mask;
         lockv = p_xnor[k] != 0 ? mask : 32'h0;
         if (rst) begin
            m_out[k] = p_init[k]; m_anchor[k] = p_init[k];
            m_cnt[k] = 0; m_period[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
         end else if (ld) begin
            m_wrap[k] = 0; m_cnt[k] = 0;
            if (s == lockv) begin
               m_out[k] = p_init[k]; m_anchor[k] = p_init[k]; m_lock[k] = 1;
            end else begin
               m_out[k] = s; m_anchor[k] = s; m_lock[k] = 0;
            end
         end else if (en) begin
            m_lock[k] = 0;
            nx = m_out[k];
            for (int j = 0; j < p_step[k]; j++) nx = m_next(k, nx);
            m_out[k] = nx;
            if (nx == m_anchor[k]) begin
               m_wrap[k] = 1; m_period[k] = (m_cnt[k] + 1) & mask; m_cnt[k] = 0;
            end else begin
               m_wrap[k] = 0;
               if (m_cnt[k] != mask) m_cnt[k] = m_cnt[k] + 1;
            end
         end else begin
            m_wrap[k] = 0; m_lock[k] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_inst(input int k, input logic [31:0] o, input logic [31:0] w,
                           input logic [31:0] p, input logic [31:0] c, input logic [31:0] l);
      chk($sformatf("m%0d.out", k), o, m_out[k]);
      chk($sformatf("m%0d.wrap", k), w, m_wrap[k]);
      chk($sformatf("m%0d.period", k), p, m_period[k]);
      chk($sformatf("m%0d.step_cnt", k), c, m_cnt[k]);
      chk($sformatf("m%0d.lock_err", k), l, m_lock[k]);
   endtask

   task automatic tick();
      model_clk(reset, enable, load, {16'h0, seed16});
      @(posedge clk);
      #1;
      chk_inst(0, o0, w0, p0, c0, l0);
      chk_inst(1, o1, w1, p1, c1, l1);
      chk_inst(2, o2, w2, p2, c2, l2);
   endtask

   logic [15:0] exp0[4];
   logic [3:0]  exp2[16];
   int          wraps;

   initial begin
      p_w    = '{16, 16, 4};
      p_taps = '{32'hB400, 32'hB400, 32'hC};
      p_xnor = '{1, 1, 0};
      p_init = '{32'h0, 32'h0, 32'h1};
      p_step = '{1, 4, 1};
      exp0   = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
      exp2   = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};

      // Reset state
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst.out", {16'h0, o0}, 32'h0);
      chk("rst.period", {16'h0, p0}, 32'h0);
      chk("rst.step_cnt", {16'h0, c0}, 32'h0);
      chk("rst.d2_out", {28'h0, o2}, 32'h1);

      // Directed sequences from reset
      enable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i < 4) begin
            chk("seq.d0_out", {16'h0, o0}, {16'h0, exp0[i]});
            chk("seq.d0_cnt", {16'h0, c0}, i + 1);
         end
         if (i == 0) begin
            chk("step4.out", {16'h0, o1}, 32'h000F);
            chk("step4.cnt", {16'h0, c1}, 32'h1);
         end
         chk("xor4.out", {28'h0, o2}, {28'h0, exp2[i + 1]});
         chk("xor4.wrap", {31'h0, w2}, (i == 14) ? 32'h1 : 32'h0);
         if (i == 14) chk("xor4.period", {28'h0, p2}, 32'd15);
      end

      // Full period of the default generator
      enable = 1'b0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
      enable = 1'b1;
      wraps  = 0;
      for (int i = 0; i < 65535; i++) begin
         tick();
         if (w0 === 1'b1) wraps++;
         chk("full.wrap", {31'h0, w0}, (i == 65534) ? 32'h1 : 32'h0);
         if (i == 65534) begin
            chk("full.out", {16'h0, o0}, 32'h0);
            chk("full.period", {16'h0, p0}, 32'hFFFF);
            chk("full.step_cnt", {16'h0, c0}, 32'h0);
         end
      end
      chk("full.wrap_count", wraps, 1);

      // Lock-up seed rejected, legal seed accepted
      enable = 1'b0;
      load   = 1'b1;
      seed16 = 16'hFFFF;
      tick();
      chk("lock.out", {16'h0, o0}, 32'h0);
      chk("lock.err", {31'h0, l0}, 32'h1);
      chk("lock.cnt", {16'h0, c0}, 32'h0);
      chk("lock.period_kept", {16'h0, p0}, 32'hFFFF);
      load = 1'b0;
      tick();
      chk("lock.err_pulse", {31'h0, l0}, 32'h0);
      load   = 1'b1;
      seed16 = 16'h1234;
      tick();
      chk("seed.out", {16'h0, o0}, 32'h1234);
      chk("seed.err", {31'h0, l0}, 32'h0);

      // Load wins over enable
      enable = 1'b1;
      seed16 = 16'h00A5;
      tick();
      chk("ldenb.out", {16'h0, o0}, 32'h00A5);
      load = 1'b0;
      tick();
      chk("ldenb.next", {16'h0, o0}, 32'h014B);

      // Reset overrides load and enable mid-run
      reset  = 1'b1;
      load   = 1'b1;
      seed16 = 16'h1234;
      tick();
      chk("midrst.out", {16'h0, o0}, 32'h0);
      chk("midrst.period", {16'h0, p0}, 32'h0);
      chk("midrst.cnt", {16'h0, c0}, 32'h0);
      chk("midrst.wrap", {31'h0, w0}, 32'h0);
      chk("midrst.err", {31'h0, l0}, 32'h0);
      reset = 1'b0;
      load  = 1'b0;

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 199) == 0);
         load   = ($urandom_range(0, 15) == 0);
         enable = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       seed16 = 16'hFFFF;
            1:       seed16 = 16'h0000;
            default: seed16 = 16'($urandom);
         endcase
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
